// File: rtl/video_res_detect_pkg.sv
// Shared definitions for the resolution detector and the quad-split stages
// that consume its measured boundaries.
package video_res_detect_pkg;

  // Lock state machine encoding
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } res_state_e;

  // Edge convention: a frame starts on the vs transition into VS_ACTIVE,
  // a line ends on the de transition out of DE_ACTIVE.
  localparam logic VS_ACTIVE = 1'b1;
  localparam logic DE_ACTIVE = 1'b1;

  // Width of the consecutive-frame match counter (LOCK_FRAMES up to 15)
  localparam int MATCH_W = 4;

  // Half of a size value, used for the quadrant split points
  function automatic logic [31:0] half_of(input logic [31:0] size);
    return {1'b0, size[31:1]};
  endfunction

endpackage

// File: rtl/video_edge_detect.sv
// Delays vs/de by one cycle and reports the frame-start and line-end edges.
module video_edge_detect
  import video_res_detect_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic vs_i,
  input  logic de_i,
  output logic vs_rise_o,
  output logic de_fall_o
);

  logic vs_d0_r;
  logic de_d0_r;

  // Previous-cycle copies of vs and de
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vs_d0_r <= 1'b0;
      de_d0_r <= 1'b0;
    end else begin
      vs_d0_r <= vs_i;
      de_d0_r <= de_i;
    end
  end

  assign vs_rise_o = (vs_i == VS_ACTIVE) && (vs_d0_r != VS_ACTIVE);
  assign de_fall_o = (de_d0_r == DE_ACTIVE) && (de_i != DE_ACTIVE);

endmodule

// File: rtl/video_res_detect.sv
// Measures active width/height of the incoming video timing and publishes a
// stable resolution (plus half-split points) once it repeats LOCK_FRAMES times.
// Pure side-channel: the video stream itself is not touched.
module video_res_detect
  import video_res_detect_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 3,
  parameter int MIN_H       = 16,
  parameter int MIN_V       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             vs_i,
  input  logic             hs_i,
  input  logic             de_i,
  output logic [CNT_W-1:0] h_active_o,
  output logic [CNT_W-1:0] v_active_o,
  output logic [CNT_W-1:0] h_half_o,
  output logic [CNT_W-1:0] v_half_o,
  output logic             locked_o,
  output logic             frame_start_o
);

  localparam logic [CNT_W-1:0]   CNT_MAX       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   MIN_H_C       = CNT_W'(MIN_H);
  localparam logic [CNT_W-1:0]   MIN_V_C       = CNT_W'(MIN_V);
  localparam logic [MATCH_W-1:0] LOCK_C        = MATCH_W'(LOCK_FRAMES);
  localparam logic [MATCH_W-1:0] MATCH_ONE     = {{(MATCH_W-1){1'b0}}, 1'b1};
  localparam logic [MATCH_W-1:0] MATCH_ZERO    = {MATCH_W{1'b0}};
  localparam logic               LOCK_ON_FIRST = (LOCK_FRAMES == 1);

  // hs carries no information the measurement needs
  logic hs_unused_s;
  assign hs_unused_s = hs_i;

  logic vs_rise_s;
  logic de_fall_s;

  video_edge_detect u_edge (
    .clock     (clock),
    .reset_n   (reset_n),
    .vs_i      (vs_i),
    .de_i      (de_i),
    .vs_rise_o (vs_rise_s),
    .de_fall_o (de_fall_s)
  );

  // Measurement state
  logic [CNT_W-1:0] pix_cnt_r;
  logic [CNT_W-1:0] line_cnt_r;
  logic [CNT_W-1:0] ref_w_r;
  logic             mismatch_r;
  logic             ovf_r;
  logic             primed_r;
  logic             discard_r;

  // Lock state
  res_state_e         state_r;
  res_state_e         state_n_s;
  logic [MATCH_W-1:0] match_cnt_r;
  logic [MATCH_W-1:0] match_n_s;
  logic [CNT_W-1:0]   cand_w_r;
  logic [CNT_W-1:0]   cand_h_r;
  logic [CNT_W-1:0]   cand_w_n_s;
  logic [CNT_W-1:0]   cand_h_n_s;

  // A line that was already running when the frame started belongs to no frame
  logic line_end_s;
  logic first_line_s;
  logic line_ovf_s;
  logic width_bad_s;
  logic [CNT_W-1:0] line_cnt_inc_s;

  assign line_end_s     = de_fall_s && !discard_r;
  assign first_line_s   = (line_cnt_r == CNT_ZERO);
  assign line_ovf_s     = line_end_s && (line_cnt_r == CNT_MAX);
  assign width_bad_s    = line_end_s && !first_line_s && (pix_cnt_r != ref_w_r);
  assign line_cnt_inc_s = (line_cnt_r == CNT_MAX) ? CNT_MAX : (line_cnt_r + CNT_ONE);

  // Frame evaluation includes a line that ends on the very frame-start cycle
  logic [CNT_W-1:0] meas_w_s;
  logic [CNT_W-1:0] meas_h_s;
  logic             frame_ok_s;
  logic             cand_match_s;
  logic             lock_entry_s;

  assign meas_w_s     = (line_end_s && first_line_s) ? pix_cnt_r : ref_w_r;
  assign meas_h_s     = line_end_s ? line_cnt_inc_s : line_cnt_r;
  assign frame_ok_s   = primed_r && !(mismatch_r || width_bad_s) &&
                        !(ovf_r || line_ovf_s) &&
                        (meas_w_s >= MIN_H_C) && (meas_h_s >= MIN_V_C);
  assign cand_match_s = (meas_w_s == cand_w_r) && (meas_h_s == cand_h_r);
  assign lock_entry_s = (state_n_s == ST_LOCKED) && (state_r != ST_LOCKED);

  // Pixel/line counting, width consistency and overflow tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pix_cnt_r  <= CNT_ZERO;
      line_cnt_r <= CNT_ZERO;
      ref_w_r    <= CNT_ZERO;
      mismatch_r <= 1'b0;
      ovf_r      <= 1'b0;
      primed_r   <= 1'b0;
      discard_r  <= 1'b0;
    end else if (vs_rise_s) begin
      pix_cnt_r  <= CNT_ZERO;
      line_cnt_r <= CNT_ZERO;
      ref_w_r    <= CNT_ZERO;
      mismatch_r <= 1'b0;
      ovf_r      <= 1'b0;
      primed_r   <= 1'b1;
      discard_r  <= (de_i == DE_ACTIVE);
    end else if (de_fall_s) begin
      pix_cnt_r <= CNT_ZERO;
      discard_r <= 1'b0;
      if (line_end_s) begin
        line_cnt_r <= line_cnt_inc_s;
        if (first_line_s) begin
          ref_w_r <= pix_cnt_r;
        end
        if (width_bad_s) begin
          mismatch_r <= 1'b1;
        end
        if (line_ovf_s) begin
          ovf_r <= 1'b1;
        end
      end
    end else if (de_i == DE_ACTIVE) begin
      if (pix_cnt_r == CNT_MAX) begin
        ovf_r <= 1'b1;
      end else begin
        pix_cnt_r <= pix_cnt_r + CNT_ONE;
      end
    end
  end

  // Lock FSM: next state and candidate, only moved on frame starts
  always_comb begin
    state_n_s  = state_r;
    match_n_s  = match_cnt_r;
    cand_w_n_s = cand_w_r;
    cand_h_n_s = cand_h_r;
    if (vs_rise_s) begin
      case (state_r)
        ST_SEARCH: begin
          if (frame_ok_s) begin
            cand_w_n_s = meas_w_s;
            cand_h_n_s = meas_h_s;
            match_n_s  = MATCH_ONE;
            state_n_s  = LOCK_ON_FIRST ? ST_LOCKED : ST_CHECK;
          end else begin
            match_n_s = MATCH_ZERO;
          end
        end
        ST_CHECK: begin
          if (frame_ok_s && cand_match_s) begin
            match_n_s = match_cnt_r + MATCH_ONE;
            if (match_n_s >= LOCK_C) begin
              state_n_s = ST_LOCKED;
            end else begin
              state_n_s = ST_CHECK;
            end
          end else if (frame_ok_s) begin
            cand_w_n_s = meas_w_s;
            cand_h_n_s = meas_h_s;
            match_n_s  = MATCH_ONE;
            state_n_s  = ST_CHECK;
          end else begin
            match_n_s = MATCH_ZERO;
            state_n_s = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (frame_ok_s && cand_match_s) begin
            state_n_s = ST_LOCKED;
          end else if (frame_ok_s) begin
            // Drop lock but start counting the new resolution right away
            cand_w_n_s = meas_w_s;
            cand_h_n_s = meas_h_s;
            match_n_s  = MATCH_ONE;
            state_n_s  = LOCK_ON_FIRST ? ST_LOCKED : ST_CHECK;
          end else begin
            match_n_s = MATCH_ZERO;
            state_n_s = ST_SEARCH;
          end
        end
        default: begin
          match_n_s = MATCH_ZERO;
          state_n_s = ST_SEARCH;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Lock FSM state and candidate registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= ST_SEARCH;
      match_cnt_r <= MATCH_ZERO;
      cand_w_r    <= CNT_ZERO;
      cand_h_r    <= CNT_ZERO;
    end else begin
      state_r     <= state_n_s;
      match_cnt_r <= match_n_s;
      cand_w_r    <= cand_w_n_s;
      cand_h_r    <= cand_h_n_s;
    end
  end

  // Published outputs; sizes only change when a new lock is reached
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h_active_o    <= CNT_ZERO;
      v_active_o    <= CNT_ZERO;
      h_half_o      <= CNT_ZERO;
      v_half_o      <= CNT_ZERO;
      locked_o      <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      frame_start_o <= vs_rise_s;
      locked_o      <= (state_n_s == ST_LOCKED);
      if (lock_entry_s) begin
        h_active_o <= cand_w_n_s;
        v_active_o <= cand_h_n_s;
        h_half_o   <= CNT_W'(half_of(32'(cand_w_n_s)));
        v_half_o   <= CNT_W'(half_of(32'(cand_h_n_s)));
      end
    end
  end

endmodule

// File: tb/tb_video_res_detect.sv
// Scoreboard bench: two detectors (12-bit and 6-bit counters) watch the same
// generated video timing; a frame-level reference model predicts the
// published state at every frame start.
module tb_video_res_detect;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic vs = 1'b0;
  logic hs = 1'b0;
  logic de = 1'b0;

  always #5 clock = ~clock;

  logic [11:0] h0, v0, hh0, vh0;
  logic        lk0, fs0;
  logic [5:0]  h1, v1, hh1, vh1;
  logic        lk1, fs1;

  video_res_detect #(.CNT_W(12), .LOCK_FRAMES(3), .MIN_H(16), .MIN_V(16)) dut0 (
    .clock(clock), .reset_n(reset_n), .vs_i(vs), .hs_i(hs), .de_i(de),
    .h_active_o(h0), .v_active_o(v0), .h_half_o(hh0), .v_half_o(vh0),
    .locked_o(lk0), .frame_start_o(fs0));

  video_res_detect #(.CNT_W(6), .LOCK_FRAMES(3), .MIN_H(16), .MIN_V(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .vs_i(vs), .hs_i(hs), .de_i(de),
    .h_active_o(h1), .v_active_o(v1), .h_half_o(hh1), .v_half_o(vh1),
    .locked_o(lk1), .frame_start_o(fs1));

  typedef struct {
    bit locked;
    int h;
    int v;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: lines completed in the open frame, plus per-instance lock view
  int   cw[2] = '{12, 6};
  bit   primed = 1'b0;
  int   lines_q[$];
  bit   m_locked[2];
  int   m_run[2];
  int   m_cw[2];
  int   m_ch[2];
  int   m_h[2];
  int   m_v[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    hs = 1'($urandom_range(0, 1));
  endtask

  // Close the open frame in the model and queue the expected published state
  task automatic frame_end();
    for (int i = 0; i < 2; i++) begin
      int   mx;
      int   w;
      int   h;
      bit   ok;
      exp_t e;
      mx = (1 << cw[i]) - 1;
      h  = lines_q.size();
      w  = (h > 0) ? lines_q[0] : 0;
      ok = primed && (w >= 16) && (h >= 16) && (w <= mx) && (h <= mx);
      foreach (lines_q[k]) if (lines_q[k] != w) ok = 1'b0;
      if (!ok) begin
        m_run[i]    = 0;
        m_locked[i] = 1'b0;
      end else if (m_run[i] > 0 && w == m_cw[i] && h == m_ch[i]) begin
        if (m_run[i] < 3) m_run[i]++;
        if (m_run[i] == 3 && !m_locked[i]) begin
          m_locked[i] = 1'b1;
          m_h[i] = w;
          m_v[i] = h;
        end
      end else begin
        m_cw[i] = w;
        m_ch[i] = h;
        m_run[i] = 1;
        m_locked[i] = 1'b0;
      end
      e.locked = m_locked[i];
      e.h = m_h[i];
      e.v = m_v[i];
      if (i == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
    lines_q.delete();
    primed = 1'b1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    de = 1'b0;
    frame_end();
    repeat (3) cyc();
    vs = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lk0"}, lk0, 0); chk({tag, "_h0"}, h0, 0); chk({tag, "_v0"}, v0, 0);
    chk({tag, "_hh0"}, hh0, 0); chk({tag, "_vh0"}, vh0, 0); chk({tag, "_fs0"}, fs0, 0);
    chk({tag, "_lk1"}, lk1, 0); chk({tag, "_h1"}, h1, 0); chk({tag, "_v1"}, v1, 0);
    chk({tag, "_fs1"}, fs1, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vs = 1'b0;
    de = 1'b0;
    cyc();
    check_zero("reset");
    cyc();
    reset_n = 1'b1;
    chk("reset_pending0", exp_q0.size(), 0);
    chk("reset_pending1", exp_q1.size(), 0);
    primed = 1'b0;
    lines_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 1'b0; m_run[i] = 0; m_cw[i] = 0; m_ch[i] = 0; m_h[i] = 0; m_v[i] = 0;
    end
    repeat (2) cyc();
  endtask

  // One frame: vs pulse, vertical blanking, then nlines active lines.
  // coincide leaves de high after the last pixel so the next frame's vs rise
  // lands on the same cycle as that line's end.
  task automatic drive_frame(input int w, input int nlines, input int bad_line,
                             input int bad_w, input bit coincide, input int reset_at);
    vs_pulse();
    for (int l = 0; l < nlines; l++) begin
      int lw;
      if (l == reset_at) begin
        do_reset();
        return;
      end
      lw = (l == bad_line) ? bad_w : w;
      de = 1'b1;
      repeat (lw) cyc();
      lines_q.push_back(lw);
      if (!(coincide && l == nlines - 1)) begin
        de = 1'b0;
        repeat ($urandom_range(2, 5)) cyc();
      end
    end
  endtask

  // Scoreboard monitors: one transaction per frame_start pulse
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && fs0) begin
      if (exp_q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL fs0_unexpected: got pulse expected none at %0t", $time);
      end else begin
        e = exp_q0.pop_front();
        chk("locked0", lk0, e.locked);
        chk("h_active0", h0, e.h);
        chk("v_active0", v0, e.v);
        chk("h_half0", hh0, e.h / 2);
        chk("v_half0", vh0, e.v / 2);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && fs1) begin
      if (exp_q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL fs1_unexpected: got pulse expected none at %0t", $time);
      end else begin
        e = exp_q1.pop_front();
        chk("locked1", lk1, e.locked);
        chk("h_active1", h1, e.h);
        chk("v_active1", v1, e.v);
        chk("h_half1", hh1, e.h / 2);
        chk("v_half1", vh1, e.v / 2);
      end
    end
  end

  initial begin
    int ws[5] = '{16, 15, 16, 20, 24};
    int hs_[5] = '{16, 16, 15, 17, 18};
    do_reset();
    // Lock on 64x36: first vs rise closes the unprimed partial frame
    repeat (5) drive_frame(64, 36, -1, 0, 1'b0, -1);
    // Switch to 32x20: lock drops, sizes hold, relock after two more
    repeat (3) drive_frame(32, 20, -1, 0, 1'b0, -1);
    // Back to 64x36, then one frame with a 63-pixel line
    repeat (3) drive_frame(64, 36, -1, 0, 1'b0, -1);
    drive_frame(64, 36, 10, 63, 1'b0, -1);
    // Three good frames, the middle one ending its last line on the vs rise
    drive_frame(64, 36, -1, 0, 1'b0, -1);
    drive_frame(64, 36, -1, 0, 1'b1, -1);
    drive_frame(64, 36, -1, 0, 1'b0, -1);
    // 80-pixel line overflows the 6-bit counter; then 16x16 locks both
    drive_frame(16, 16, 3, 80, 1'b0, -1);
    repeat (4) drive_frame(16, 16, -1, 0, 1'b0, -1);
    // Randomized frames around the minimum-size boundary
    for (int f = 0; f < 12; f++) begin
      int sel;
      int bad;
      sel = $urandom_range(0, 4);
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 14) : -1;
      drive_frame(ws[sel], hs_[sel], bad, ws[sel] + 1, 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) drive_frame(ws[sel], hs_[sel], -1, 0, 1'b0, -1);
    end
    // Lock on 32x20, then reset in the middle of a frame and relock
    repeat (3) drive_frame(32, 20, -1, 0, 1'b0, -1);
    drive_frame(32, 20, -1, 0, 1'b0, 8);
    repeat (4) drive_frame(32, 20, -1, 0, 1'b0, -1);
    vs_pulse();
    repeat (4) cyc();
    chk("drain0", exp_q0.size(), 0);
    chk("drain1", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
